// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths: clock/baud
// defaults, the bit-period helper and the receiver state encoding.
package uart_pkg;

  localparam int unsigned SYS_CLK_FRE_DEF = 100_000_000;
  localparam int unsigned BPS_DEF         = 9600;
  localparam int unsigned CLK_CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // System clocks per serial bit period.
  function automatic logic [CLK_CNT_W-1:0] bps_cnt(input int unsigned clk_hz,
                                                   input int unsigned bps);
    return CLK_CNT_W'(clk_hz / bps);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single 8N1 byte receiver: input synchroniser, start/data/stop FSM and
// mid-bit sampling. Strobes are combinational; the frame layer registers them.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FRE = SYS_CLK_FRE_DEF,
  parameter int unsigned BPS         = BPS_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] byte_c_o,
  output logic       byte_valid_c_o,
  output logic       stop_err_c_o,
  output logic       start_c_o,
  output logic       idle_c_o,
  output logic       busy_o
);

  localparam logic [CLK_CNT_W-1:0] BPS_CNT  = bps_cnt(SYS_CLK_FRE, BPS);
  localparam logic [CLK_CNT_W-1:0] HALF_END = CLK_CNT_W'(BPS_CNT / 2 - 1);
  localparam logic [CLK_CNT_W-1:0] BIT_END  = CLK_CNT_W'(BPS_CNT - 1);

  logic [1:0]           rxd_sync_q;
  logic                 rxd_edge_q;
  rx_state_e            state_q, state_d;
  logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 busy_q;
  logic                 rxd_s;
  logic                 fall_c;

  assign rxd_s    = rxd_sync_q[1];
  assign fall_c   = rxd_edge_q & ~rxd_s;
  assign byte_c_o = shift_q;
  assign idle_c_o = (state_q == IDLE);
  assign busy_o   = busy_q;

  // Stop bit is sampled one full period after bit 7, i.e. half a bit early,
  // so the FSM is already idle when a back-to-back start edge arrives.
  always_comb begin
    state_d        = state_q;
    clk_cnt_d      = clk_cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    byte_valid_c_o = 1'b0;
    stop_err_c_o   = 1'b0;
    start_c_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_c) begin
          start_c_o = 1'b1;
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_END) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rxd_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d      = '0;
          state_d        = IDLE;
          byte_valid_c_o = rxd_s;
          stop_err_c_o   = ~rxd_s;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rxd_sync_q <= 2'b11;
      rxd_edge_q <= 1'b1;
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      rxd_sync_q <= {rxd_sync_q[0], rxd_i};
      rxd_edge_q <= rxd_s;
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      busy_q     <= (state_d != IDLE);
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Frame assembler on top of the byte receiver: collects NUM_BYTES good bytes
// into one frame and reports stop-bit errors and inter-byte timeouts.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FRE  = SYS_CLK_FRE_DEF,
  parameter int unsigned BPS          = BPS_DEF,
  parameter int unsigned NUM_BYTES    = 10,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   uart_rxd,
  output logic [7:0]             rx_data,
  output logic                   rx_byte_valid,
  output logic [0:8*NUM_BYTES-1] frame_data,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic                   err_cause,
  output logic                   rx_busy
);

  localparam int unsigned FRAME_W = 8 * NUM_BYTES;
  localparam int unsigned BPS_CNT = 32'(bps_cnt(SYS_CLK_FRE, BPS));
  localparam int unsigned GAP_MAX = TIMEOUT_BITS * BPS_CNT;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
  localparam int unsigned CNT_W   = 4;
  localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(GAP_MAX - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  logic [7:0]         byte_c;
  logic               byte_valid_c, stop_err_c, start_c, idle_c, gap_run_c;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [0:FRAME_W-1] frame_q, frame_d;
  logic [0:FRAME_W-1] frame_data_q, frame_data_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               byte_valid_q, byte_valid_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               err_cause_q, err_cause_d;

  uart_rx_byte #(
    .SYS_CLK_FRE (SYS_CLK_FRE),
    .BPS         (BPS)
  ) u_rx_byte (
    .clk_i          (sys_clk),
    .rst_ni         (sys_rst_n),
    .rxd_i          (uart_rxd),
    .byte_c_o       (byte_c),
    .byte_valid_c_o (byte_valid_c),
    .stop_err_c_o   (stop_err_c),
    .start_c_o      (start_c),
    .idle_c_o       (idle_c),
    .busy_o         (rx_busy)
  );

  assign gap_run_c     = idle_c && (byte_cnt_q != '0);
  assign rx_data       = rx_data_q;
  assign rx_byte_valid = byte_valid_q;
  assign frame_data    = frame_data_q;
  assign frame_valid   = frame_valid_q;
  assign frame_err     = frame_err_q;
  assign err_cause     = err_cause_q;

  // A timeout in the same cycle as a start edge is applied first, so the
  // incoming byte opens a fresh frame.
  always_comb begin
    byte_cnt_d    = byte_cnt_q;
    gap_d         = gap_q;
    frame_d       = frame_q;
    frame_data_d  = frame_data_q;
    rx_data_d     = rx_data_q;
    err_cause_d   = err_cause_q;
    byte_valid_d  = 1'b0;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    if (gap_run_c) begin
      if (gap_q == GAP_END) begin
        frame_err_d = 1'b1;
        err_cause_d = 1'b1;
        byte_cnt_d  = '0;
        gap_d       = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
    if (start_c) begin
      gap_d = '0;
    end
    if (stop_err_c) begin
      frame_err_d = 1'b1;
      err_cause_d = 1'b0;
      byte_cnt_d  = '0;
      gap_d       = '0;
    end
    if (byte_valid_c) begin
      rx_data_d    = byte_c;
      byte_valid_d = 1'b1;
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
        if (byte_cnt_q == CNT_W'(k)) begin
          frame_d[8*k +: 8] = byte_c;
        end
      end
      if (byte_cnt_q == LAST_BYTE) begin
        frame_data_d  = frame_d;
        frame_valid_d = 1'b1;
        byte_cnt_d    = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      byte_cnt_q    <= '0;
      gap_q         <= '0;
      frame_q       <= '0;
      frame_data_q  <= '0;
      rx_data_q     <= '0;
      byte_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cause_q   <= 1'b0;
    end else begin
      byte_cnt_q    <= byte_cnt_d;
      gap_q         <= gap_d;
      frame_q       <= frame_d;
      frame_data_q  <= frame_data_d;
      rx_data_q     <= rx_data_d;
      byte_valid_q  <= byte_valid_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_cause_q   <= err_cause_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: vector table, directed corner cases and randomised
// byte streams compared against a queue-based frame model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int unsigned CLK_HZ  = 500;
  localparam int unsigned BAUD    = 10;
  localparam int unsigned NB      = 10;
  localparam int unsigned TO_BITS = 20;
  localparam int BIT   = 50;     // CLK_HZ / BAUD
  localparam int T_GAP = 1000;   // TO_BITS * BIT
  localparam int FW    = 8 * NB;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          uart_rxd = 1'b1;
  logic [7:0]    rx_data;
  logic          rx_byte_valid;
  logic [0:FW-1] frame_data;
  logic          frame_valid, frame_err, err_cause, rx_busy;

  uart_rx_frame #(
    .SYS_CLK_FRE  (CLK_HZ),
    .BPS          (BAUD),
    .NUM_BYTES    (NB),
    .TIMEOUT_BITS (TO_BITS)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .uart_rxd      (uart_rxd),
    .rx_data       (rx_data),
    .rx_byte_valid (rx_byte_valid),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .frame_err     (frame_err),
    .err_cause     (err_cause),
    .rx_busy       (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Observed strobes and the model's expected strobes.
  logic [7:0]    got_b[$], exp_b[$], acc[$];
  logic [FW-1:0] got_f[$], exp_f[$];
  logic          got_e[$], exp_e[$];
  int cyc = 0, last_bv_cyc = 0, err_cyc = 0, orphan_fv = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (rx_byte_valid) begin
      got_b.push_back(rx_data);
      last_bv_cyc = cyc;
    end
    if (frame_valid) begin
      got_f.push_back(frame_data);
      if (!rx_byte_valid) orphan_fv++;
    end
    if (frame_err) begin
      got_e.push_back(err_cause);
      err_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: good bytes accumulate until NB make a frame; a bad stop
  // bit or a long idle with a partial frame pending is a frame error.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [FW-1:0] f;
    if (ok) begin
      exp_b.push_back(b);
      acc.push_back(b);
      if (acc.size() == NB) begin
        f = '0;
        foreach (acc[k]) f = (f << 8) | FW'(acc[k]);
        exp_f.push_back(f);
        acc.delete();
      end
    end else begin
      exp_e.push_back(1'b0);
      acc.delete();
    end
  endtask

  task automatic model_timeout();
    if (acc.size() != 0) begin
      exp_e.push_back(1'b1);
      acc.delete();
    end
  endtask

  task automatic hold(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
    if (n >= T_GAP) model_timeout();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, input int len);
    hold(1'b0, len);
    for (int i = 0; i < 8; i++) hold(b[i], len);
    hold(ok, len);
    if (!ok) hold(1'b1, len);
    model_byte(b, ok);
  endtask

  task automatic check_events(input string tag);
    chk({tag, " byte count"}, got_b.size(), exp_b.size());
    foreach (exp_b[i]) if (i < got_b.size()) chk($sformatf("%s byte %0d", tag, i), got_b[i], exp_b[i]);
    chk({tag, " frame count"}, got_f.size(), exp_f.size());
    foreach (exp_f[i]) if (i < got_f.size()) chk($sformatf("%s frame %0d", tag, i), got_f[i], exp_f[i]);
    chk({tag, " error count"}, got_e.size(), exp_e.size());
    foreach (exp_e[i]) if (i < got_e.size()) chk($sformatf("%s err_cause %0d", tag, i), got_e[i], exp_e[i]);
    got_b.delete(); exp_b.delete(); got_f.delete(); exp_f.delete(); got_e.delete(); exp_e.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " rx_data"}, rx_data, 0);
    chk({tag, " rx_byte_valid"}, rx_byte_valid, 0);
    chk({tag, " frame_data"}, frame_data, 0);
    chk({tag, " frame_valid"}, frame_valid, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " err_cause"}, err_cause, 0);
    chk({tag, " rx_busy"}, rx_busy, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ok;
    int         len;
    logic [7:0] exp_rx;
    bit         exp_err;
  } vec_t;

  vec_t       tbl [6];
  int         e0;
  logic [7:0] b;
  logic [7:0] part;
  bit         ok;
  int         len;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 50, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 49, 8'h3C, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 50, 8'h3C, 1'b1};
    tbl[3] = '{8'h00, 1'b1, 51, 8'h00, 1'b0};
    tbl[4] = '{8'h81, 1'b1, 50, 8'h81, 1'b0};
    tbl[5] = '{8'h7E, 1'b0, 51, 8'h81, 1'b1};

    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_all_zero("reset");

    // Single bytes with nominal and +-2% bit periods, some with bad stop bits.
    for (int v = 0; v < 6; v++) begin
      e0 = got_e.size();
      send_byte(tbl[v].data, tbl[v].ok, tbl[v].len);
      idle(20);
      chk($sformatf("vec%0d rx_data", v), rx_data, tbl[v].exp_rx);
      chk($sformatf("vec%0d err strobes", v), got_e.size() - e0, tbl[v].exp_err);
      if (tbl[v].exp_err) chk($sformatf("vec%0d err_cause", v), err_cause, 0);
      chk($sformatf("vec%0d rx_busy", v), rx_busy, 0);
    end
    check_events("table");

    // Ten back-to-back bytes form one frame.
    for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b1, BIT);
    idle(20);
    chk("frame 01..0A", frame_data, 80'h0102030405060708090A);
    chk("frame_valid without byte strobe", orphan_fv, 0);
    check_events("frame");

    // Short low glitch is rejected at the start-bit sample.
    hold(1'b0, BIT / 4);
    idle(3 * BIT);
    chk("glitch rx_busy", rx_busy, 0);
    check_events("glitch");

    // Bad stop bit on the third byte, then a clean frame.
    send_byte(8'h55, 1'b1, BIT);
    send_byte(8'h66, 1'b1, BIT);
    send_byte(8'h77, 1'b0, BIT);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i), 1'b1, BIT);
    idle(20);
    chk("frame 10..19", frame_data, 80'h10111213141516171819);
    check_events("stoperr");

    // Four bytes then silence: timeout exactly T_GAP cycles after the 4th strobe.
    for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), 1'b1, BIT);
    idle(T_GAP + 100);
    chk("timeout latency", err_cyc - last_bv_cyc, T_GAP);
    chk("timeout err_cause", err_cause, 1);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1, BIT);
    idle(20);
    check_events("timeout");

    // Reset during data bit 4 of the third byte of a frame.
    send_byte(8'h5A, 1'b1, BIT);
    send_byte(8'hC6, 1'b1, BIT);
    part = 8'hC3;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(part[i], BIT);
    hold(part[4], BIT / 2);
    chk("busy mid-byte", rx_busy, 1);
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_all_zero("midreset");
    sys_rst_n = 1'b1;
    acc.delete();
    idle(2 * BIT);
    send_byte(8'h3C, 1'b1, BIT);
    idle(20);
    chk("post-reset rx_data", rx_data, 8'h3C);
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b1, BIT);
    idle(20);
    check_events("reset");

    // Random bytes, baud skew, bad stop bits and occasional long idles.
    for (int r = 0; r < 40; r++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 9) != 0);
      len = 49 + int'($urandom_range(0, 2));
      send_byte(b, ok, len);
      if ($urandom_range(0, 19) == 0) idle(T_GAP + 100);
      else idle(int'($urandom_range(0, 150)));
    end
    idle(T_GAP + 100);
    check_events("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receiver that deserialises 8N1 bytes from the serial line and assembles a fixed-length multi-byte frame. It is the receive-side counterpart of the game board's frame transmitter, so the two boards can exchange score/track packets. It emits a per-byte strobe and a whole-frame strobe, and flags stop-bit errors and inter-byte timeouts.

## Interface
- SYS_CLK_FRE, 100_000_000, system clock frequency in Hz
- BPS, 9600, baud rate
- NUM_BYTES, 10, bytes per frame (1..15)
- TIMEOUT_BITS, 20, idle bit-periods tolerated between bytes of one frame
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  reset, synchronous, active-low
- uart_rxd  in  1  asynchronous serial input, idle high
- rx_data  out  8  last received byte, first wire bit in bit 0
- rx_byte_valid  out  1  one-cycle pulse, rx_data updated
- frame_data  out  [0:8*NUM_BYTES-1]  last complete frame
- frame_valid  out  1  one-cycle pulse, frame_data updated
- frame_err  out  1  one-cycle pulse, partial frame discarded
- err_cause  out  1  0 = bad stop bit, 1 = timeout; held until next error
- rx_busy  out  1  high from start-edge detect until stop-bit sample

## Operation
- Local constant BPS_CNT = SYS_CLK_FRE/BPS (10416 at defaults); clk_cnt is 16 bits.
- Synchroniser: two flops on uart_rxd plus one edge register, all reset to 1.
- The FSM has four states: IDLE, START, DATA, STOP.
- IDLE → START: falling edge on the synchronised line. clk_cnt is cleared.
- START: at clk_cnt == BPS_CNT/2-1, sample the line. If it is 0, go to DATA. If it is 1, this is a glitch: return to IDLE with no outputs.
- DATA: sample every BPS_CNT clocks, 8 bits, LSB first. Wire bit i goes to byte bit i.
- STOP: sample BPS_CNT later, then return to IDLE. This is half a bit early, which allows resync on back-to-back bytes.
  - Stop bit = 1: rx_data is loaded and rx_byte_valid pulses. The byte is stored in the frame shift register at frame[8k:8k+7], with wire bit 0 in frame[8k+7] and wire bit 7 in frame[8k]. byte_cnt is incremented.
  - Stop bit = 0: frame_err pulses, err_cause is set to 0, byte_cnt is cleared, and the byte is dropped.
- Frame complete: when byte_cnt reaches NUM_BYTES-1 and a good stop bit arrives, frame_data is loaded and frame_valid pulses in the same cycle as rx_byte_valid. byte_cnt then wraps to 0.
- Timeout: the gap counter runs only in IDLE with byte_cnt ≠ 0, and is cleared on a start edge. When it reaches TIMEOUT_BITS*BPS_CNT: frame_err pulses, err_cause is set to 1, and byte_cnt is cleared.
- A frame error and a start edge in the same cycle: the error is applied first, and the new byte begins a new frame.
- frame_data and rx_data hold their values between strobes. A partial frame never alters frame_data.

## Timing
- Let E be the cycle in which the edge register sees 1→0. Sample points:
  - Start-bit sample: E + BPS_CNT/2.
  - Data bit i: E + BPS_CNT/2 + (i+1)*BPS_CNT.
  - Stop bit: E + BPS_CNT/2 + 9*BPS_CNT.
- rx_byte_valid, frame_valid and frame_err are registered and assert 1 cycle after the deciding sample.
- The pin-to-E latency is 3 cycles.
- Tolerates ±2% baud mismatch.
- Reset values: rx_data 0, rx_byte_valid 0, frame_data 0, frame_valid 0, frame_err 0, err_cause 0, rx_busy 0. FSM is in IDLE and all counters are 0.
- Reset asserted mid-byte aborts reception and discards the partial frame. No strobe fires in the reset cycle.

## Structure
- A shared package uart_pkg holds:
  - SYS_CLK_FRE and BPS defaults;
  - a BPS_CNT helper function;
  - the rx state enum (IDLE/START/DATA/STOP).
- The transmit side also uses uart_pkg.
- One sub-module, uart_rx_byte: synchroniser, FSM and bit sampling. It outputs a byte, a valid pulse and a stop-error pulse.
- uart_rx_frame holds byte_cnt, the frame shift register and the gap timer.

## Test plan
- Single byte 0xA5 at 9600 baud → rx_data = 0xA5 and one rx_byte_valid pulse; no frame_valid; rx_busy deasserts.
- Ten bytes 0x01..0x0A back-to-back → one frame_valid coincident with the 10th rx_byte_valid; frame_data = 0x0102030405060708090A.
- Low glitch on uart_rxd lasting BPS_CNT/4 clocks → FSM returns to IDLE; no strobes.
- Byte 3 sent with stop bit 0 → frame_err with err_cause = 0. Then ten fresh bytes 0x10..0x19 → frame_valid with exactly those bytes.
- Four bytes, then line idle → frame_err with err_cause = 1, exactly 20*BPS_CNT cycles after the 4th stop sample (+1 cycle). The next full frame is received intact.
- sys_rst_n low for 2 cycles during data bit 4 → all outputs are 0. The next byte 0x3C is received correctly.
